ula_issue_ctrl: RTL and testbench
=================================

Name: ula_issue_ctrl

Overview:
Multi-cycle instruction issue and sequencing controller that drives the ALU datapath (ulaCore plus its In1/In2 operand muxes) from the instruction side.
- Accepts one 32-bit MIPS R/I-type ALU instruction per transaction via valid/ready.
- Decodes it, reads the register file, and drives the ALU opcode, mux selects and operands.
- Captures the ALU result and zero flag, then presents a write-back transaction with back-pressure.

Parameters:
DATA_W, 32, datapath width (ALU operands and result)
REG_AW, 5, register file address width

Ports:
clock  in  1  single clock; all state updates on rising edge
reset  in  1  synchronous, active-high reset
instr_valid  in  1  instruction word offered
instr_ready  out  1  controller can accept an instruction
instr  in  32  MIPS instruction word
rf_rd_en  out  1  register file read strobe
rf_rs_addr  out  REG_AW  rs field
rf_rt_addr  out  REG_AW  rt field
rf_rs_data  in  DATA_W  rs data, valid cycle after rf_rd_en
rf_rt_data  in  DATA_W  rt data, valid cycle after rf_rd_en
alu_op  out  5  ALU operation code (0..14)
alu_in1_sel  out  2  00 rt, 01 sign-ext imm, 10 zero-ext imm
alu_in2_sel  out  1  0 rs, 1 shamt
alu_rt  out  DATA_W  rt operand to In1 mux
alu_rs  out  DATA_W  rs operand to In2 mux
alu_imm  out  16  raw immediate
alu_ext_imm  out  DATA_W  sign-extended immediate
alu_shamt  out  5  shamt field
alu_result  in  DATA_W  ALU result (combinational from ALU)
alu_zero  in  1  ALU zero flag
wb_valid  out  1  write-back transaction pending
wb_ready  in  1  write-back consumer ready
wb_we  out  1  register write enable (0 when destination is $0)
wb_addr  out  REG_AW  destination register
wb_data  out  DATA_W  captured result
wb_zero  out  1  captured zero flag
illegal  out  1  one-cycle pulse on unsupported instruction

Behaviour:
Reset:
- State IDLE.
- All outputs 0, except instr_ready=1.
- Internal registers cleared.
- Reset in any state aborts the in-flight instruction; no wb_valid or illegal is produced for it.

FSM (IDLE -> DECODE -> EXEC -> WB -> IDLE):
- IDLE: instr_ready=1. On instr_valid, latch instr and go to DECODE. instr_ready=0 in all other states.
- DECODE:
  - Drive rf_rd_en=1, rf_rs_addr=instr[25:21], rf_rt_addr=instr[20:16].
  - Register the decoded op, selects and destination.
  - If unsupported: pulse illegal=1, rf_rd_en=0, return to IDLE.
  - Otherwise go to EXEC.
- EXEC:
  - alu_rs/alu_rt = rf_rs_data/rf_rt_data.
  - alu_op, selects, alu_imm, alu_ext_imm = {{16{imm[15]}},imm} and alu_shamt are all stable for the whole cycle.
  - At the end of the cycle, capture alu_result into wb_data and alu_zero into wb_zero. Go to WB.
- WB:
  - wb_valid=1; wb_addr/wb_data/wb_zero/wb_we held stable until wb_ready.
  - When wb_valid and wb_ready are both high: complete, go to IDLE.
- Latency: acceptance edge at cycle 0 -> wb_valid first high at cycle 3. Minimum 4 cycles per instruction with wb_ready tied high.
- alu_op and selects are 0 outside EXEC. The ALU output is only sampled in EXEC.

Decode, R-type (opcode 0), destination rd=instr[15:11]:
- sll funct 00: op0, sel1=00, sel2=1
- srl funct 02: op1, sel1=00, sel2=1
- sra funct 03: op2, sel1=00, sel2=1
- sllv funct 04: op3, sel1=00, sel2=0
- srlv funct 06: op4, sel1=00, sel2=0
- srav funct 07: op5, sel1=00, sel2=0
- add/addu funct 20/21: op6
- sub/subu funct 22/23: op7
- and funct 24: op8
- or funct 25: op9
- xor funct 26: op10
- nor funct 27: op11
- slt funct 2A: op12
- sltu funct 2B: op13
- All other funct values: illegal.

Decode, I-type (sel2=0), destination rt:
- addi/addiu 08/09: op6, sel1=01
- slti 0A: op12, sel1=01
- sltiu 0B: op13, sel1=01
- andi 0C: op8, sel1=10
- ori 0D: op9, sel1=10
- xori 0E: op10, sel1=10
- lui 0F: op14, sel1=10
- Any other opcode: illegal.

Write-back rules:
- Destination $0 (wb_addr=0): wb_we=0, but the WB handshake still occurs.
- No overflow trapping; add and addu behave identically.
- instr_valid arriving while busy is ignored; instr_ready=0 is the only back-pressure mechanism.

Test Plan:
- Reset, then add $3,$1,$2 (0x00221820) with rs_data=5, rt_data=7 -> alu_op=6, sel1=00, sel2=0 in EXEC; at cycle 3 wb_valid=1, wb_addr=3, wb_data=12, wb_we=1.
- sll $4,$2,3 (0x000220C0), rt_data=0x1 -> alu_op=0, sel2=1, alu_shamt=3; wb_addr=4, wb_data=0x8.
- addi $5,$1,-1 (0x2025FFFF), rs_data=1 -> alu_ext_imm=0xFFFFFFFF, sel1=01; wb_data=0, wb_zero=1, wb_addr=5.
- lui $6,0x1234 (0x3C061234) with wb_ready low for 5 cycles -> wb_valid and wb_data=0x12340000 held stable; instr_ready=0 until the handshake completes.
- Opcode 0x23 (lw) or R-type funct 0x18 -> illegal pulses exactly 1 cycle in DECODE; no wb_valid; instr_ready=1 the next cycle.
- Assert reset during EXEC -> next cycle IDLE, instr_ready=1, wb_valid=0; a following add $0,$1,$2 gives wb_valid=1 with wb_we=0.

Source files
------------

// File: rtl/ula_issue_ctrl.sv
// Issue/sequencing controller for the ulaCore datapath.
// Accepts one ALU instruction at a time and hands the result to write-back.
module ula_issue_ctrl #(
    parameter int DATA_W = 32,
    parameter int REG_AW = 5
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              instr_valid,
    output logic              instr_ready,
    input  logic [31:0]       instr,
    output logic              rf_rd_en,
    output logic [REG_AW-1:0] rf_rs_addr,
    output logic [REG_AW-1:0] rf_rt_addr,
    input  logic [DATA_W-1:0] rf_rs_data,
    input  logic [DATA_W-1:0] rf_rt_data,
    output logic [4:0]        alu_op,
    output logic [1:0]        alu_in1_sel,
    output logic              alu_in2_sel,
    output logic [DATA_W-1:0] alu_rt,
    output logic [DATA_W-1:0] alu_rs,
    output logic [15:0]       alu_imm,
    output logic [DATA_W-1:0] alu_ext_imm,
    output logic [4:0]        alu_shamt,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic              wb_valid,
    input  logic              wb_ready,
    output logic              wb_we,
    output logic [REG_AW-1:0] wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_zero,
    output logic              illegal
);

    typedef enum logic [1:0] {
        IDLE,
        DECODE,
        EXEC,
        WB
    } state_t;

    typedef struct packed {
        logic              legal;
        logic [4:0]        op;
        logic [1:0]        sel1;
        logic              sel2;
        logic [REG_AW-1:0] dest;
    } dec_t;

    state_t state;
    dec_t   dec_now;
    dec_t   dec_q;
    logic [15:0] imm_q;

    function automatic dec_t decode(input logic [31:0] iw);
        dec_t d;
        d       = '0;
        d.legal = 1'b1;
        if (iw[31:26] == 6'h00) begin
            d.dest = REG_AW'(iw[15:11]);
            case (iw[5:0])
                6'h00: begin d.op = 5'd0;  d.sel2 = 1'b1; end
                6'h02: begin d.op = 5'd1;  d.sel2 = 1'b1; end
                6'h03: begin d.op = 5'd2;  d.sel2 = 1'b1; end
                6'h04: d.op = 5'd3;
                6'h06: d.op = 5'd4;
                6'h07: d.op = 5'd5;
                6'h20, 6'h21: d.op = 5'd6;
                6'h22, 6'h23: d.op = 5'd7;
                6'h24: d.op = 5'd8;
                6'h25: d.op = 5'd9;
                6'h26: d.op = 5'd10;
                6'h27: d.op = 5'd11;
                6'h2A: d.op = 5'd12;
                6'h2B: d.op = 5'd13;
                default: d.legal = 1'b0;
            endcase
        end else begin
            d.dest = REG_AW'(iw[20:16]);
            case (iw[31:26])
                6'h08, 6'h09: begin d.op = 5'd6;  d.sel1 = 2'b01; end
                6'h0A: begin d.op = 5'd12; d.sel1 = 2'b01; end
                6'h0B: begin d.op = 5'd13; d.sel1 = 2'b01; end
                6'h0C: begin d.op = 5'd8;  d.sel1 = 2'b10; end
                6'h0D: begin d.op = 5'd9;  d.sel1 = 2'b10; end
                6'h0E: begin d.op = 5'd10; d.sel1 = 2'b10; end
                6'h0F: begin d.op = 5'd14; d.sel1 = 2'b10; end
                default: d.legal = 1'b0;
            endcase
        end
        return d;
    endfunction

    assign dec_now = decode(instr);

    // Register file data is only meaningful the cycle after the read strobe.
    assign alu_rs = (state == EXEC) ? rf_rs_data : '0;
    assign alu_rt = (state == EXEC) ? rf_rt_data : '0;

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            instr_ready <= 1'b1;
            dec_q       <= '0;
            imm_q       <= '0;
            rf_rd_en    <= 1'b0;
            rf_rs_addr  <= '0;
            rf_rt_addr  <= '0;
            illegal     <= 1'b0;
            alu_op      <= '0;
            alu_in1_sel <= '0;
            alu_in2_sel <= 1'b0;
            alu_imm     <= '0;
            alu_ext_imm <= '0;
            alu_shamt   <= '0;
            wb_valid    <= 1'b0;
            wb_we       <= 1'b0;
            wb_addr     <= '0;
            wb_data     <= '0;
            wb_zero     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (instr_valid) begin
                        state       <= DECODE;
                        instr_ready <= 1'b0;
                        dec_q       <= dec_now;
                        imm_q       <= instr[15:0];
                        rf_rs_addr  <= REG_AW'(instr[25:21]);
                        rf_rt_addr  <= REG_AW'(instr[20:16]);
                        rf_rd_en    <= dec_now.legal;
                        illegal     <= ~dec_now.legal;
                    end
                end
                DECODE: begin
                    rf_rd_en <= 1'b0;
                    illegal  <= 1'b0;
                    if (dec_q.legal) begin
                        state       <= EXEC;
                        alu_op      <= dec_q.op;
                        alu_in1_sel <= dec_q.sel1;
                        alu_in2_sel <= dec_q.sel2;
                        alu_imm     <= imm_q;
                        alu_ext_imm <= {{(DATA_W-16){imm_q[15]}}, imm_q};
                        alu_shamt   <= imm_q[10:6];
                    end else begin
                        state       <= IDLE;
                        instr_ready <= 1'b1;
                    end
                end
                EXEC: begin
                    state       <= WB;
                    wb_valid    <= 1'b1;
                    wb_data     <= alu_result;
                    wb_zero     <= alu_zero;
                    wb_addr     <= dec_q.dest;
                    wb_we       <= (dec_q.dest != '0);
                    alu_op      <= '0;
                    alu_in1_sel <= '0;
                    alu_in2_sel <= 1'b0;
                    alu_imm     <= '0;
                    alu_ext_imm <= '0;
                    alu_shamt   <= '0;
                end
                WB: begin
                    if (wb_ready) begin
                        state       <= IDLE;
                        wb_valid    <= 1'b0;
                        instr_ready <= 1'b1;
                    end
                end
                default: begin
                    state       <= IDLE;
                    instr_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ula_issue_ctrl.sv
// Scoreboard bench for ula_issue_ctrl; the bench also plays the ALU
// and register file so the write-back data comes from real operands.
module tb_ula_issue_ctrl;

    logic        clock = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic        rf_rd_en;
    logic [4:0]  rf_rs_addr;
    logic [4:0]  rf_rt_addr;
    logic [31:0] rf_rs_data;
    logic [31:0] rf_rt_data;
    logic [4:0]  alu_op;
    logic [1:0]  alu_in1_sel;
    logic        alu_in2_sel;
    logic [31:0] alu_rt;
    logic [31:0] alu_rs;
    logic [15:0] alu_imm;
    logic [31:0] alu_ext_imm;
    logic [4:0]  alu_shamt;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        wb_valid;
    logic        wb_ready;
    logic        wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        wb_zero;
    logic        illegal;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [4:0]  addr;
        logic [31:0] data;
        logic        zero;
        logic        we;
    } wb_t;

    wb_t exp_q[$];

    ula_issue_ctrl dut (
        .clock(clock), .reset(reset),
        .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
        .rf_rd_en(rf_rd_en), .rf_rs_addr(rf_rs_addr), .rf_rt_addr(rf_rt_addr),
        .rf_rs_data(rf_rs_data), .rf_rt_data(rf_rt_data),
        .alu_op(alu_op), .alu_in1_sel(alu_in1_sel), .alu_in2_sel(alu_in2_sel),
        .alu_rt(alu_rt), .alu_rs(alu_rs), .alu_imm(alu_imm),
        .alu_ext_imm(alu_ext_imm), .alu_shamt(alu_shamt),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_we(wb_we),
        .wb_addr(wb_addr), .wb_data(wb_data), .wb_zero(wb_zero),
        .illegal(illegal)
    );

    always #5 clock = ~clock;

    // ALU model fed by the DUT's operand muxes
    logic [31:0] in1, in2;
    always_comb begin
        in1 = alu_rt;
        if (alu_in1_sel == 2'b01) in1 = alu_ext_imm;
        if (alu_in1_sel == 2'b10) in1 = {16'h0, alu_imm};
        in2 = alu_in2_sel ? {27'h0, alu_shamt} : alu_rs;
        alu_result = '0;
        case (alu_op)
            5'd0, 5'd3: alu_result = in1 << in2[4:0];
            5'd1, 5'd4: alu_result = in1 >> in2[4:0];
            5'd2, 5'd5: alu_result = $signed(in1) >>> in2[4:0];
            5'd6:  alu_result = in2 + in1;
            5'd7:  alu_result = in2 - in1;
            5'd8:  alu_result = in2 & in1;
            5'd9:  alu_result = in2 | in1;
            5'd10: alu_result = in2 ^ in1;
            5'd11: alu_result = ~(in2 | in1);
            5'd12: alu_result = {31'h0, $signed(in2) < $signed(in1)};
            5'd13: alu_result = {31'h0, in2 < in1};
            5'd14: alu_result = in1 << 16;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == 32'h0);
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Monitor: every accepted write-back is matched against the scoreboard
    always @(negedge clock) begin
        if (!reset && wb_valid && wb_ready) begin
            if (exp_q.size() == 0) begin
                chk("wb_unexpected", 32'h1, 32'h0);
            end else begin
                wb_t e;
                e = exp_q.pop_front();
                chk("wb_addr", {27'h0, wb_addr}, {27'h0, e.addr});
                chk("wb_data", wb_data, e.data);
                chk("wb_zero", {31'h0, wb_zero}, {31'h0, e.zero});
                chk("wb_we", {31'h0, wb_we}, {31'h0, e.we});
            end
        end
    end

    task automatic wait_ready();
        int n = 0;
        while (!instr_ready && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        chk("instr_ready_idle", {31'h0, instr_ready}, 32'h1);
    endtask

    task automatic issue(input logic [31:0] iw, input logic [31:0] rs,
                         input logic [31:0] rt, input logic [4:0] op,
                         input logic [1:0] s1, input logic s2,
                         input logic [4:0] addr, input logic [31:0] data,
                         input logic z, input logic we, input int hold);
        int n;
        wait_ready();
        instr = iw; instr_valid = 1'b1;
        rf_rs_data = rs; rf_rt_data = rt;
        wb_ready = (hold == 0);
        @(posedge clock); #1;
        instr_valid = 1'b0; instr = 32'h0;
        chk("dec_rd_en", {31'h0, rf_rd_en}, 32'h1);
        chk("dec_rs_addr", {27'h0, rf_rs_addr}, {27'h0, iw[25:21]});
        chk("dec_rt_addr", {27'h0, rf_rt_addr}, {27'h0, iw[20:16]});
        chk("dec_illegal", {31'h0, illegal}, 32'h0);
        chk("dec_ready", {31'h0, instr_ready}, 32'h0);
        exp_q.push_back('{addr, data, z, we});
        @(posedge clock); #1;
        chk("exec_op", {27'h0, alu_op}, {27'h0, op});
        chk("exec_sel1", {30'h0, alu_in1_sel}, {30'h0, s1});
        chk("exec_sel2", {31'h0, alu_in2_sel}, {31'h0, s2});
        chk("exec_rs", alu_rs, rs);
        chk("exec_rt", alu_rt, rt);
        chk("exec_shamt", {27'h0, alu_shamt}, {27'h0, iw[10:6]});
        chk("exec_ext_imm", alu_ext_imm, {{16{iw[15]}}, iw[15:0]});
        chk("exec_wb_valid", {31'h0, wb_valid}, 32'h0);
        @(posedge clock); #1;
        chk("wb_valid_c3", {31'h0, wb_valid}, 32'h1);
        chk("wb_op_cleared", {27'h0, alu_op}, 32'h0);
        for (int i = 0; i < hold; i++) begin
            chk("hold_valid", {31'h0, wb_valid}, 32'h1);
            chk("hold_data", wb_data, data);
            chk("hold_ready", {31'h0, instr_ready}, 32'h0);
            @(posedge clock); #1;
        end
        wb_ready = 1'b1;
        n = 0;
        while (wb_valid && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        chk("wb_done", {31'h0, wb_valid}, 32'h0);
        chk("ready_after_wb", {31'h0, instr_ready}, 32'h1);
    endtask

    task automatic issue_illegal(input logic [31:0] iw);
        wait_ready();
        instr = iw; instr_valid = 1'b1;
        @(posedge clock); #1;
        instr_valid = 1'b0; instr = 32'h0;
        chk("ill_pulse", {31'h0, illegal}, 32'h1);
        chk("ill_rd_en", {31'h0, rf_rd_en}, 32'h0);
        @(posedge clock); #1;
        chk("ill_pulse_end", {31'h0, illegal}, 32'h0);
        chk("ill_ready", {31'h0, instr_ready}, 32'h1);
        chk("ill_no_wb", {31'h0, wb_valid}, 32'h0);
    endtask

    initial begin
        reset = 1'b1; instr_valid = 1'b0; instr = 32'h0;
        rf_rs_data = 32'h0; rf_rt_data = 32'h0; wb_ready = 1'b1;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_ready", {31'h0, instr_ready}, 32'h1);
        chk("rst_wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("rst_op", {27'h0, alu_op}, 32'h0);
        chk("rst_rd_en", {31'h0, rf_rd_en}, 32'h0);
        chk("rst_wb_data", wb_data, 32'h0);

        //     instr         rs            rt       op    s1     s2  addr data          z  we hold
        issue(32'h00221820, 32'd5,       32'd7,   5'd6,  2'b00, 0, 5'd3, 32'd12,       0, 1, 0);
        issue(32'h000220C0, 32'h0,       32'h1,   5'd0,  2'b00, 1, 5'd4, 32'h8,        0, 1, 0);
        issue(32'h2025FFFF, 32'd1,       32'h0,   5'd6,  2'b01, 0, 5'd5, 32'h0,        1, 1, 0);
        issue(32'h3C061234, 32'h0,       32'h0,   5'd14, 2'b10, 0, 5'd6, 32'h12340000, 0, 1, 5);
        issue(32'h00223822, 32'd10,      32'd3,   5'd7,  2'b00, 0, 5'd7, 32'd7,        0, 1, 0);
        issue(32'h0022402A, 32'hFFFFFFFF,32'd1,   5'd12, 2'b00, 0, 5'd8, 32'd1,        0, 1, 0);
        issue(32'h34298001, 32'h10000,   32'h0,   5'd9,  2'b10, 0, 5'd9, 32'h18001,    0, 1, 0);

        issue_illegal(32'h8C220000);
        issue_illegal(32'h00220018);

        // reset while the add sits in EXEC must drop it silently
        wait_ready();
        instr = 32'h00221820; instr_valid = 1'b1;
        rf_rs_data = 32'd1; rf_rt_data = 32'd2;
        @(posedge clock); #1;
        instr_valid = 1'b0;
        @(posedge clock); #1;
        chk("pre_rst_exec_op", {27'h0, alu_op}, 32'd6);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        chk("abort_ready", {31'h0, instr_ready}, 32'h1);
        chk("abort_wb_valid", {31'h0, wb_valid}, 32'h0);
        chk("abort_op", {27'h0, alu_op}, 32'h0);
        repeat (3) @(posedge clock);
        #1 chk("abort_still_quiet", {31'h0, wb_valid}, 32'h0);

        issue(32'h00220020, 32'd1, 32'd2, 5'd6, 2'b00, 0, 5'd0, 32'd3, 0, 0, 0);

        repeat (2) @(posedge clock);
        chk("scoreboard_empty", exp_q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
